// File: rtl/btable_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : btable_port_arbiter
// Purpose  : Port-A arbiter for the blockB table. Round-robin between two
//            single-beat requesters. When BTABLE_ARB_INIT_EN is defined, the
//            table is first cleared to zero after reset.
// Revision : 1.0
// ============================================================================
module btable_port_arbiter #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                init_done
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic              run;
  logic              ptr;
  logic [1:0]        grant;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_ok;
  logic [1:0]        rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_rd_q;

`ifdef BTABLE_ARB_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;
  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              init_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + ADDR_W'(1);
      if (init_cnt == LAST_ADDR) state <= S_RUN;
    end
  end

  // Gating with rst keeps the port quiet while reset is still held.
  assign run     = (state == S_RUN) && !rst;
  assign init_wr = (state == S_INIT) && !rst;
`else
  assign run = !rst;
`endif

  always_comb begin
    grant = 2'b00;
    if (run) begin
      if (req_valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                    grant = req_valid;
    end
    sel       = grant[1];
    sel_we    = req_we[sel];
    sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    addr_ok   = {1'b0, sel_addr} < DEPTH_EXT;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
`ifdef BTABLE_ARB_INIT_EN
    if (init_wr) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = init_cnt;
    end else
`endif
    if ((grant != 2'b00) && addr_ok) begin
      mem_en    = 1'b1;
      mem_we    = sel_we;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      if (grant != 2'b00) ptr <= ~sel;
      rsp_valid_q <= grant;
      rsp_err_q   <= (grant != 2'b00) && !addr_ok;
      rsp_rd_q    <= (grant != 2'b00) && addr_ok && !sel_we;
    end
  end

  // A response pending when reset arrives must never reach the requesters.
  assign req_ready = grant;
  assign rsp_valid = rst ? 2'b00 : rsp_valid_q;
  assign rsp_err   = rsp_err_q && !rst;
  assign rsp_rdata = (rsp_rd_q && !rst) ? mem_rdata : '0;
  assign init_done = run;

endmodule
`default_nettype wire

// File: tb/tb_btable_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_btable_port_arbiter
// Purpose  : Randomized scoreboard bench for btable_port_arbiter (DEPTH=48),
//            covering both BTABLE_ARB_INIT_EN builds.
// Revision : 1.0
// ============================================================================
module tb_btable_port_arbiter;

  localparam int DEPTH  = 48;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata = '0;
  logic                init_done;

  btable_port_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Port-A RAM; unwritten words return a recognisable fill pattern.
  bit [31:0] ram [64];
  bit        ram_wr [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
      end
    end
  end

  typedef struct {
    logic [1:0]  v;
    logic        err;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  // Reference model: expected table contents and arbitration history.
  logic [31:0] refm [64];
  int          cyc = 0;
  logic        last_id = 1'b1;
  bit          rst_seen = 1'b0;
  int          gcnt [2] = '{0, 0};

  always @(posedge clk) begin : p_capture
    logic        done_e;
    logic [1:0]  er;
    logic        id;
    logic [5:0]  a;
    logic        w;
    logic [31:0] d;
    if (rst) begin
      if (rst_seen) begin
        chk("rst_ctrl", {req_ready, rsp_valid, rsp_err, init_done, mem_en, mem_we, mem_addr}, '0);
        chk("rst_data", {rsp_rdata, mem_wdata}, '0);
      end else begin
        for (int i = 0; i < 64; i++) refm[i] = pat(i);
      end
`ifdef BTABLE_ARB_INIT_EN
      for (int i = 0; i < 64; i++) refm[i] = (i < DEPTH) ? 32'h0 : pat(i);
`endif
      rst_seen = 1'b1;
      cyc      = 0;
      last_id  = 1'b1;
      sb.delete();
    end else if (rst_seen) begin
      cyc++;
`ifdef BTABLE_ARB_INIT_EN
      done_e = (cyc > DEPTH);
      if (cyc <= DEPTH)
        chk("init_wr", {mem_en, mem_we, mem_addr, mem_wdata},
            {1'b1, 1'b1, 6'(cyc - 1), 32'h0});
`else
      done_e = 1'b1;
`endif
      chk("init_done", init_done, done_e);
      if (!done_e)                 er = 2'b00;
      else if (req_valid == 2'b11) er = (last_id == 1'b0) ? 2'b10 : 2'b01;
      else                         er = req_valid;
      chk("ready", req_ready, er);
      if (er != 2'b00) begin
        id = er[1];
        a  = req_addr[id*ADDR_W +: ADDR_W];
        w  = req_we[id];
        d  = req_wdata[id*DATA_W +: DATA_W];
        if (int'(a) >= DEPTH) begin
          chk("oor_mem_en", mem_en, 1'b0);
          sb.push_back('{v: er, err: 1'b1, rd: 32'h0});
        end else begin
          chk("mem_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, w, a, d});
          if (w) begin
            refm[a] = d;
            sb.push_back('{v: er, err: 1'b0, rd: 32'h0});
          end else begin
            sb.push_back('{v: er, err: 1'b0, rd: refm[a]});
          end
        end
        last_id = id;
        gcnt[id]++;
      end else if (done_e) begin
        chk("idle_mem_en", mem_en, 1'b0);
      end
    end
  end

  always @(negedge clk) begin : p_monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (rst) chk("rsp_dropped_on_rst", rsp_valid, 2'b00);
      else     chk("rsp", {rsp_valid, rsp_err, rsp_rdata}, {e.v, e.err, e.rd});
    end else begin
      chk("rsp_none", rsp_valid, 2'b00);
    end
  end

  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input logic [5:0] a0, input logic [5:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_we    = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!init_done && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("init_timeout", init_done, 1'b1);
  endtask

  initial begin
    int g0;
    int g1;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    wait_done();

    // Write then read of the same address from requester 0.
    step(2'b01, 2'b01, 6'd5, 6'd0, 32'hDEADBEEF, 32'h0);
    step(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0);
    step(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);

    // Out-of-range read and write.
    step(2'b10, 2'b00, 6'd0, 6'd50, 32'h0, 32'h0);
    step(2'b01, 2'b01, 6'd60, 6'd0, 32'h1234_5678, 32'h0);
    step(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);

    // Reset the cycle after a read accept.
    step(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0);
    req_valid = 2'b00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    wait_done();

    // Continuous contention right after reset.
    g0 = gcnt[0];
    g1 = gcnt[1];
    for (int i = 0; i < 8; i++)
      step(2'b11, 2'($urandom), 6'($urandom_range(0, 47)), 6'($urandom_range(0, 47)),
           $urandom, $urandom);
    chk("contention_g0", 32'(gcnt[0] - g0), 32'd4);
    chk("contention_g1", 32'(gcnt[1] - g1), 32'd4);
    step(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);

    // Random traffic, including out-of-range addresses.
    for (int i = 0; i < 400; i++)
      step(2'($urandom), 2'($urandom), 6'($urandom_range(0, 55)), 6'($urandom_range(0, 55)),
           $urandom, $urandom);

    step(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btable_port_arbiter.md
# btable_port_arbiter

Arbiter and initialiser for port A of the blockB table memory (dual-port, `MEMORYB_WORDS` deep). After reset, it clears every table word to zero. It then shares port A between two datapath requesters using round-robin, single-beat read/write transactions. Port B remains dedicated to the register (APB) path and is outside this block.

## Interface
- `DEPTH`, default 64: number of table words; any value ≥ 2.
- `DATA_W`, default 32: table word width.
- `ADDR_W`, default `$clog2(DEPTH)`: address width.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  2  per-requester request valid; bit index = requester id.
- `req_ready`  out  2  per-requester accept.
- `req_we`  in  2  1 = write, 0 = read.
- `req_addr`  in  2×ADDR_W  request address.
- `req_wdata`  in  2×DATA_W  write data.
- `rsp_valid`  out  2  one-cycle response strobe (reads and writes).
- `rsp_err`  out  1  response address was out of range; qualified by `rsp_valid`.
- `rsp_rdata`  out  DATA_W  read data; qualified by `rsp_valid`; 0 for writes and errors.
- `mem_en`  out  1  port A enable.
- `mem_we`  out  1  port A write.
- `mem_addr`  out  ADDR_W  port A address.
- `mem_wdata`  out  DATA_W  port A write data.
- `mem_rdata`  in  DATA_W  port A read data, valid one cycle after a read enable.
- `init_done`  out  1  table clear complete; requests are served only when this is 1.

## Operation
- **States:**
  - INIT: entered on `rst`. Writes 0 to addresses 0..DEPTH-1, one per cycle (`mem_en=mem_we=1`). On address DEPTH-1, moves to RUN.
  - RUN: serves requests. Stays in RUN until `rst`.
- **Acceptance in INIT:** `req_ready = 2'b00`.
- **Acceptance in RUN:**
  - One request is accepted per cycle.
  - With a single valid, that requester is granted.
  - With both valid, the round-robin pointer picks. The pointer resets to requester 0.
  - After each grant, the pointer moves to the other requester.
- **Grant path:** `req_ready` is combinational from `req_valid`, state and pointer. `req_ready` is one-hot or zero. A requester may drop `req_valid` without being accepted.
- **Memory command:** issued in the same cycle as the accept, carrying the granted requester's `we`, `addr` and `wdata`.
- **Responses:** exactly one response per accepted request, on the cycle after acceptance, on the granted requester's `rsp_valid` bit.
  - Read: `rsp_rdata = mem_rdata`.
  - Write: `rsp_rdata = 0`.
- **Out-of-range address** (`req_addr ≥ DEPTH`; only possible when DEPTH is not a power of 2):
  - The request is accepted and `mem_en` stays 0.
  - The response has `rsp_err=1` and `rsp_rdata=0`.
- **Back-to-back accepts:** responses are pipelined at one per cycle. There is no response backpressure.
- **Reset mid-INIT or mid-RUN:** state, counter, pointer and the pending response are discarded. The next cycle begins INIT at address 0. A response pending at reset is never delivered.

## Timing
- **Reset values:**
  - `req_ready=0`, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `init_done=0`.
  - `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- **INIT duration:** the first cycle after `rst` deasserts writes address 0. INIT lasts exactly DEPTH cycles, and `init_done` rises on the cycle after the address DEPTH-1 write.
- **Latency:** accept at cycle N gives the response at N+1.
- **Throughput:** 1 transaction per cycle aggregate. Under continuous contention each requester gets 1 transaction per 2 cycles.
- **Hazard:** a write followed by a read of the same address on the next cycle returns the new data. This relies on memory write-before-read ordering across cycles. There is no forwarding inside the block.

## Configuration
- Macro: `BTABLE_ARB_INIT_EN`.
- **Defined:** INIT state and clear engine are present, as described above.
- **Undefined:**
  - There is no clear engine and the table contents are unspecified after reset.
  - RUN is entered on the first cycle after `rst` deasserts, with `init_done=1` from that cycle.
  - No INIT writes appear on the memory port.

## Test plan
- **Reset then idle, DEPTH=64, macro defined:** expect 64 consecutive zero writes to addresses 0..63, `init_done` rising at cycle 65, and `req_ready=0` throughout INIT.
- **Write then read, requester 0:** write 0xDEADBEEF to address 5, then read address 5 on the next cycle. Expect a write response (`rsp_rdata=0`), then a read response of 0xDEADBEEF one cycle after the read accept.
- **Continuous contention:** both requesters hold `req_valid` for 8 cycles. Expect grants alternating 0,1,0,1…, starting with 0 after reset, 4 grants each, and responses alternating on `rsp_valid[0]` / `rsp_valid[1]`.
- **Out of range, DEPTH=48:** read address 50. Expect `mem_en=0` and a response with `rsp_err=1`, `rsp_rdata=0`.
- **Mid-operation reset:** assert `rst` in RUN the cycle after a read accept. Expect no `rsp_valid`, then INIT restarting at address 0.
- **Macro undefined:** expect `init_done=1` on the first cycle after reset, no INIT writes, and a request accepted in that cycle.
